// File: rtl/bcd7_scan_rx.sv
// Receiver for a scanned 4-digit 7-segment display: captures stable digits and frames.
// Optional macro BCD7_RX_ERRCNT_EN enables the saturating err_cnt error counter.
module bcd7_scan_rx #(
    parameter int unsigned STABLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] anout,
    input  logic [7:0] dout,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] C,
    output logic [3:0] D,
    output logic [3:0] dp,
    output logic [3:0] valid,
    output logic       blank,
    output logic       frame_done,
    output logic       bad_seg,
    output logic       bad_an,
    output logic [7:0] err_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GOT0 = 2'd1;
    localparam logic [1:0] GOT1 = 2'd2;
    localparam logic [1:0] GOT2 = 2'd3;

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYC);

    logic [3:0]  s_an_q;
    logic [7:0]  s_seg_q;
    logic [11:0] prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  dig_q [4];
    logic [3:0]  dp_q, valid_q;
    logic [1:0]  st_q, st_d;
    logic        fd_q, fd_d;
    logic        bs_q, bs_d;
    logic        ba_q, ba_d;

    logic        changed, an_chg, fresh;
    logic        onehot, is_idle, cap;
    logic [1:0]  idx;
    logic        ok;
    logic [3:0]  val;

    function automatic logic [4:0] dec7(input logic [6:0] s);
        logic [4:0] r;
        r = 5'h0F;
        case (s)
            7'b1000000: r = {1'b1, 4'd0};
            7'b1111001: r = {1'b1, 4'd1};
            7'b0100100: r = {1'b1, 4'd2};
            7'b0110000: r = {1'b1, 4'd3};
            7'b0011001: r = {1'b1, 4'd4};
            7'b0010010: r = {1'b1, 4'd5};
            7'b0000010: r = {1'b1, 4'd6};
            7'b1111000: r = {1'b1, 4'd7};
            7'b0000000: r = {1'b1, 4'd8};
            7'b0010000: r = {1'b1, 4'd9};
            default:    r = 5'h0F;
        endcase
        return r;
    endfunction

    always_comb begin
        changed = ({s_an_q, s_seg_q} != prev_q);
        an_chg  = (s_an_q != prev_q[11:8]);
        if (changed)
            cnt_d = 8'd1;
        else if (cnt_q == 8'hFF)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 8'd1;
        // a saturated counter must not re-fire for STABLE_CYC=255
        fresh = changed || (cnt_q != 8'hFF);
    end

    always_comb begin
        onehot = 1'b1;
        idx    = 2'd0;
        unique case (1'b1)
            (s_an_q == 4'b1110): idx = 2'd0;
            (s_an_q == 4'b1101): idx = 2'd1;
            (s_an_q == 4'b1011): idx = 2'd2;
            (s_an_q == 4'b0111): idx = 2'd3;
            default:             onehot = 1'b0;
        endcase
    end

    assign is_idle   = (s_an_q == 4'b1111);
    assign cap       = onehot && fresh && (cnt_d == STABLE_C);
    assign {ok, val} = dec7(s_seg_q[6:0]);
    assign bs_d      = cap && !ok;
    assign ba_d      = !onehot && !is_idle && an_chg;

    always_comb begin
        st_d = st_q;
        fd_d = 1'b0;
        if (cap) begin
            st_d = IDLE;
            if (ok) begin
                unique case (idx)
                    2'd0: st_d = GOT0;
                    2'd1: if (st_q == GOT0) st_d = GOT1;
                    2'd2: if (st_q == GOT1) st_d = GOT2;
                    2'd3: if (st_q == GOT2) fd_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_an_q  <= 4'hF;
            s_seg_q <= 8'hFF;
            prev_q  <= 12'hFFF;
            cnt_q   <= 8'd0;
            dig_q   <= '{default: 4'hF};
            dp_q    <= 4'hF;
            valid_q <= 4'h0;
            st_q    <= IDLE;
            fd_q    <= 1'b0;
            bs_q    <= 1'b0;
            ba_q    <= 1'b0;
        end else begin
            s_an_q  <= anout;
            s_seg_q <= dout;
            prev_q  <= {s_an_q, s_seg_q};
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            fd_q    <= fd_d;
            bs_q    <= bs_d;
            ba_q    <= ba_d;
            if (cap) begin
                dig_q[idx]   <= ok ? val : 4'hF;
                dp_q[idx]    <= s_seg_q[7];
                valid_q[idx] <= ok;
            end
        end
    end

`ifdef BCD7_RX_ERRCNT_EN
    logic [7:0] err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 8'd0;
        else if ((bs_d || ba_d) && err_q != 8'hFF)
            err_q <= err_q + 8'd1;
    end
    assign err_cnt = err_q;
`else
    assign err_cnt = 8'h00;
`endif

    assign A          = dig_q[0];
    assign B          = dig_q[1];
    assign C          = dig_q[2];
    assign D          = dig_q[3];
    assign dp         = dp_q;
    assign valid      = valid_q;
    assign blank      = is_idle;
    assign frame_done = fd_q;
    assign bad_seg    = bs_q;
    assign bad_an     = ba_q;

endmodule

// File: doc/bcd7_scan_rx.md
BCD7_SCAN_RX -- requirements
Module: bcd7_scan_rx

Interface
REQ-001 Parameter STABLE_CYC, default 1, is the number of consecutive identical registered samples required before a digit is captured (legal range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 anout  input  4  scanned anode enables, active-low; bit i selects digit i (0=A .. 3=D).
REQ-005 dout  input  8  scanned segments, active-low; [6:0] = g..a, [7] = decimal point.
REQ-006 A, B, C, D  output  4 each  captured BCD value of digits 0..3; 4'hF = invalid/unknown.
REQ-007 dp  output  4  captured raw dout[7] per digit, active-low.
REQ-008 valid  output  4  bit i high when digit i holds a legally decoded value.
REQ-009 blank  output  1  high while the registered anout equals 4'b1111.
REQ-010 frame_done  output  1  one-cycle pulse when digits 0,1,2,3 are captured in order.
REQ-011 bad_seg  output  1  one-cycle pulse when a captured segment pattern is not a legal 0..9 code.
REQ-012 bad_an  output  1  one-cycle pulse when the registered anout is neither one-hot-low nor 4'b1111.
REQ-013 err_cnt  output  8  saturating error count (see Configuration).

Function
REQ-014 anout and dout shall be registered into s_an/s_seg every clock; all decisions use the registered values only.
REQ-015 A stability counter shall load 1 whenever {s_an,s_seg} differs from its previous value, and otherwise increment, saturating at 255.
REQ-016 Capture shall occur in the cycle the counter equals STABLE_CYC while s_an is one-hot-low; only one capture per dwell, re-armed by any change of s_an or s_seg.
REQ-017 Latency with STABLE_CYC=1: inputs present before edge k -> registered at edge k -> digit, dp and valid updated at edge k+1; each extra STABLE_CYC adds one edge.
REQ-018 Decode (s_seg[6:0] -> value): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9.
REQ-019 A capture with any other s_seg[6:0] shall write 4'hF, clear that valid bit, store dp, and pulse bad_seg in the same edge.
REQ-020 Sequencer states IDLE, GOT0, GOT1, GOT2: a legal capture of digit 0 -> GOT0 from any state; digit 1 in GOT0 -> GOT1; digit 2 in GOT1 -> GOT2; digit 3 in GOT2 -> IDLE with frame_done pulsed on the same edge as the D write.
REQ-021 Any out-of-order capture or bad_seg capture shall return the sequencer to IDLE (a legal digit 0 still goes to GOT0).
REQ-022 s_an == 4'b1111 shall assert blank and cause no capture; digit registers, valid and sequencer state are held.
REQ-023 s_an neither one-hot-low nor 4'b1111 shall cause no capture, hold all state, and pulse bad_an once on entry (re-armed when s_an changes).
REQ-024 When bad_seg and bad_an events coincide with err_cnt counting, err_cnt shall increase by 1 only (saturating at 255).

Reset
REQ-025 While rst is high: s_an = 4'b1111, s_seg = 8'hFF, counter = 0, A..D = 4'hF, dp = 4'b1111, valid = 0, blank = 1, frame_done = bad_seg = bad_an = 0, err_cnt = 0, sequencer = IDLE.
REQ-026 Reset asserted mid-frame shall abort the frame; no frame_done is produced for digits captured before reset.

Configuration
REQ-027 With BCD7_RX_ERRCNT_EN defined, err_cnt shall count bad_seg or bad_an cycles, saturating at 8'hFF.
REQ-028 Without BCD7_RX_ERRCNT_EN, err_cnt shall be constant 8'h00 and no counter logic shall be synthesised; all other behaviour is unchanged.

Verification
REQ-029 STABLE_CYC=1, drive per clock {anout,dout}: {1110,1_1000000},{1101,0_1111001},{1011,1_0100100},{0111,1_0110000} -> A..D = 0,1,2,3, dp = 4'b1101, valid = 4'hF, one frame_done pulse on the D-write edge.
REQ-030 STABLE_CYC=3, hold anout=1110 with dout=1_0011001 for 2 clocks then change -> no capture; hold for 3 clocks -> A = 4 on the third edge after registration, single capture despite a 10-clock dwell.
REQ-031 Capture digit 1 with seg 7'b1111111 -> B = 4'hF, valid[1] = 0, bad_seg pulses once, err_cnt = 1 with macro, 0 without.
REQ-032 Sequence D0, D2, D3 -> no frame_done; then D0, D1, D2, D3 -> exactly one frame_done.
REQ-033 anout = 4'b1111 for 20 clocks after a full frame -> blank = 1, A..D and valid unchanged; anout = 4'b1100 -> one bad_an pulse, no capture.
REQ-034 Assert rst after GOT2, release, send D3 only -> no frame_done, A..D = 4'hF except D, valid = 4'b1000.
